mssd_tx: RTL and testbench
==========================

Name: mssd_tx

Overview:
- Serial frame transmitter for the MSSD link. It is the sending end of the link that the MSSD receiver decodes.
- It accepts a frame request carrying a 2-bit destination port and a 4-bit byte count. It then pulls the payload bytes over a valid/ready handshake.
- Output frame on serOut: start bit, 6-bit header, then count×8 payload bits.
- Sits between the host-side byte source and the serial line into MSSD.

Parameters:
- GAP_BITS, default 2: idle-high cycles enforced after each frame. Used only when MSSD_TX_IDLE_GAP_EN is defined.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- port  in  2  destination port; latched on an accepted start.
- count  in  4  payload byte count, 1..15; latched on an accepted start.
- busy  out  1  frame in progress (start bit through last data bit, plus gap if enabled).
- byte_data  in  8  next payload byte, sent MSB first.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_ready  out  1  transmitter takes byte_data this cycle when byte_valid=1.
- serOut  out  1  serial line; idles high (1).
- done  out  1  one-cycle pulse when a frame completes.
- error  out  1  one-cycle pulse on a rejected request (count=0) or a payload underrun.

Behaviour:
- Reset (asynchronous, any state): serOut=1, busy=0, done=0, error=0, byte_ready=0; state=IDLE; counters and shift register cleared.
- Reset mid-frame aborts the frame immediately. No done or error pulse is issued.
- All outputs are registered except byte_ready, which is decoded from state and counters.
- States: IDLE, START, HDR, DATA, GAP (GAP exists only with the macro).
- IDLE → START: on start=1 with count≠0, sampled in cycle T0. port and count are latched.
- IDLE, start=1 with count=0: error=1 in T0+1; state stays IDLE; serOut stays 1.
- START (T1): serOut=0; busy=1.
- HDR (T2..T7): serOut = port[1], port[0], count[3], count[2], count[1], count[0], one bit per cycle, MSB first.
- byte_ready=1 in T7, the last header cycle, for the first byte.
- DATA: 8×N cycles, where N is the latched count. Each byte is sent MSB first from the shift register.
- byte_ready=1 in bit-7 cycle of bytes 1..N-1; byte_ready=0 during the last byte.
- Handshake: a byte transfers when byte_ready=1 and byte_valid=1. It is loaded into the shift register and its MSB drives serOut the next cycle.
- Underrun: byte_ready=1 with byte_valid=0.
  - Next cycle: error=1, serOut=1, busy=0, state=IDLE.
  - The partial frame is abandoned and no done pulse is issued.
- Completion: the cycle after the last data bit, T8+8N: done=1, serOut=1, busy=0.
- Bit counter is 3-bit and wraps 7→0 per byte. Byte counter is 4-bit and counts down from N; DATA exits when it reaches 0 and the bit counter is 7.
- start while busy=1 is ignored; no queuing.
- Total frame length = 7 + 8N cycles of line time.

Optional Feature:
- Macro: MSSD_TX_IDLE_GAP_EN.
- Defined: after the last data bit, enter GAP for GAP_BITS cycles.
  - serOut=1 and busy=1 throughout GAP; start is ignored.
  - done pulses in the first GAP cycle.
  - Then IDLE.
- Not defined: go directly to IDLE in the done cycle. A start sampled in that cycle is accepted, giving a back-to-back start bit on the following cycle.

Decomposition:
- Package mssd_pkg holds:
  - HDR_BITS=6, BYTE_BITS=8, PORT_W=2, CNT_W=4
  - enum tx_state_t {IDLE, START, HDR, DATA, GAP}
  - header bit-order constant
- Sub-module mssd_piso8: 8-bit parallel-in/serial-out shift register.
  - Ports: clock, reset, load, shift, din[7:0], sout.
  - Shared with header serialization by loading {port,count,2'b11}.

Test Plan:
- Basic frame: start with port=2'b10, count=4'd1, byte 8'hA5 valid → serOut = 0,1,0,0,0,0,1,1,0,1,0,0,1,0,1 over T1..T15; done=1 at T16; byte_ready high only at T7.
- Multi-byte: count=3, bytes 8'h01,8'hFF,8'h80 always valid → 31 line cycles; byte_ready high at T7, T15, T23; done at T32; exactly 3 transfers.
- Reject: start with count=0 → error pulse in the next cycle; serOut stays 1; busy stays 0.
- Underrun: count=2, byte_valid dropped at the second byte's byte_ready cycle (T15) → error at T16, serOut=1, busy=0, no done.
- Reset mid-frame: assert reset during HDR → serOut=1 and busy=0 asynchronously. A new start after release produces a clean frame.
- Back-to-back: start held high → without macro, next start bit immediately after the done cycle. With MSSD_TX_IDLE_GAP_EN and GAP_BITS=2 → exactly 2 idle-high cycles before IDLE, then the next start bit one cycle after the start is accepted.

Source files
------------

// File: rtl/mssd_pkg.sv
// Purpose: shared constants, state encoding and header layout for the MSSD serial transmitter.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package mssd_pkg;

    localparam int HDR_BITS  = 6;
    localparam int BYTE_BITS = 8;
    localparam int PORT_W    = 2;
    localparam int CNT_W     = 4;

    // Bit-counter values that mark the final header bit and the final bit of a byte.
    localparam logic [2:0] HDR_LAST_IDX = 3'(HDR_BITS - 1);
    localparam logic [2:0] BIT_LAST_IDX = 3'(BYTE_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        HDR,
        DATA,
        GAP
    } tx_state_t;

    // Header bit order on the line: the leftmost field leaves first, MSB first,
    // i.e. port[1], port[0], count[3], count[2], count[1], count[0].
    // The two fill bits pad the header to a full shift-register word and are
    // never put on the line; they are ones so the register drains toward idle.
    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [CNT_W-1:0]  count;
        logic [1:0]        fill;
    } hdr_t;

    localparam logic [1:0] HDR_FILL = 2'b11;

    function automatic logic [BYTE_BITS-1:0] hdr_word(input logic [PORT_W-1:0] port,
                                                      input logic [CNT_W-1:0]  count);
        hdr_t h;
        h.port  = port;
        h.count = count;
        h.fill  = HDR_FILL;
        return h;
    endfunction

endpackage

// File: rtl/mssd_tx_if.sv
// Purpose: groups the request, payload handshake and serial-line signals of the MSSD transmitter.
// Latency: n/a (wiring only).
// Backpressure: byte_ready/byte_valid handshake on the payload; start is only honoured while busy=0.
// Signals: start/port/count (frame request), busy, byte_data/byte_valid/byte_ready (payload),
//          serOut (serial line, idles high), done and error (one-cycle status pulses).
// Modports: master = host side that requests frames and sources bytes; slave = the transmitter.
interface mssd_tx_if;
    import mssd_pkg::*;

    logic                  start;
    logic [PORT_W-1:0]     port;
    logic [CNT_W-1:0]      count;
    logic                  busy;
    logic [BYTE_BITS-1:0]  byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  serOut;
    logic                  done;
    logic                  error;

    modport master (
        output start, port, count, byte_data, byte_valid,
        input  busy, byte_ready, serOut, done, error
    );

    modport slave (
        input  start, port, count, byte_data, byte_valid,
        output busy, byte_ready, serOut, done, error
    );

endinterface

// File: rtl/mssd_piso8.sv
// Purpose: 8-bit parallel-in/serial-out shift register, MSB first, shared by header and payload.
// Latency: sout reflects din[7] the cycle after load; each shift exposes the next bit one cycle later.
// Backpressure: none; load has priority over shift, ones are shifted in behind the data.
// Ports: clock, reset (async active-high), load, shift, din[7:0], sout (= register MSB).
module mssd_piso8 (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       sout
);

    logic [7:0] sr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[6:0], 1'b1};
        end
    end

    assign sout = sr[7];

endmodule

// File: rtl/mssd_tx.sv
// Purpose: MSSD frame transmitter: start bit, 6-bit header {port,count}, then count payload bytes MSB first.
// Latency: start sampled in T0 -> start bit in T1; done pulse in T8+8N; line time 7+8N cycles.
// Backpressure: pulls bytes with byte_ready (last header cycle, bit-7 of bytes 1..N-1); byte_valid=0 there aborts with error.
// Ports: clock, reset (async active-high), bus (mssd_tx_if.slave: start/port/count request, busy,
//        byte_data/byte_valid/byte_ready payload, serOut line, done/error pulses).
// Build option: MSSD_TX_IDLE_GAP_EN adds GAP_BITS idle-high, busy cycles after each frame.
module mssd_tx
    import mssd_pkg::*;
#(
    parameter int unsigned GAP_BITS = 2
) (
    input  logic        clock,
    input  logic        reset,
    mssd_tx_if.slave    bus
);

    if (GAP_BITS < 1 || GAP_BITS > 15) begin : g_gap_range
        $error("mssd_tx: GAP_BITS must be in 1..15");
    end

    tx_state_t            state;
    logic [2:0]           bit_cnt;
    logic [CNT_W-1:0]     byte_cnt;
    logic                 ser_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
`ifdef MSSD_TX_IDLE_GAP_EN
    logic [3:0]           gap_cnt;
`endif

    logic                 byte_ready_c;
    logic                 accept;
    logic                 hdr_load;
    logic                 piso_load;
    logic                 piso_shift;
    logic [BYTE_BITS-1:0] piso_din;
    logic                 piso_sout;

    // byte_ready is the only combinational output: it asks for the next byte
    // one cycle before the shift register runs dry, so a byte in every slot
    // keeps the line continuous.
    always_comb begin
        byte_ready_c = 1'b0;
        if (state == HDR && bit_cnt == HDR_LAST_IDX) begin
            byte_ready_c = 1'b1;
        end else if (state == DATA && bit_cnt == BIT_LAST_IDX && byte_cnt != '0) begin
            byte_ready_c = 1'b1;
        end
    end

    // Header and bytes share one shift register. A payload byte's MSB goes
    // straight into ser_q on the load edge, so the register is loaded with the
    // remaining seven bits already advanced by one.
    always_comb begin
        accept     = byte_ready_c & bus.byte_valid;
        hdr_load   = (state == IDLE) && bus.start && (bus.count != '0);
        piso_load  = hdr_load | accept;
        piso_din   = hdr_load ? hdr_word(bus.port, bus.count)
                              : {bus.byte_data[BYTE_BITS-2:0], 1'b1};
        piso_shift = (state == START)
                   || (state == HDR  && bit_cnt != HDR_LAST_IDX)
                   || (state == DATA && bit_cnt != BIT_LAST_IDX);
    end

    mssd_piso8 u_piso (
        .clock (clock),
        .reset (reset),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (piso_din),
        .sout  (piso_sout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            ser_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef MSSD_TX_IDLE_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count == '0) begin
                            error_q <= 1'b1;
                        end else begin
                            state    <= START;
                            ser_q    <= 1'b0;
                            busy_q   <= 1'b1;
                            byte_cnt <= bus.count;
                            bit_cnt  <= '0;
                        end
                    end
                end

                START: begin
                    state <= HDR;
                    ser_q <= piso_sout;
                end

                HDR: begin
                    if (bit_cnt == HDR_LAST_IDX) begin
                        if (bus.byte_valid) begin
                            state    <= DATA;
                            ser_q    <= bus.byte_data[BYTE_BITS-1];
                            byte_cnt <= byte_cnt - 4'd1;
                            bit_cnt  <= '0;
                        end else begin
                            // Underrun on the first byte: drop the frame.
                            state   <= IDLE;
                            ser_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end else begin
                        ser_q   <= piso_sout;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end

                DATA: begin
                    if (bit_cnt == BIT_LAST_IDX) begin
                        if (byte_cnt == '0) begin
                            done_q <= 1'b1;
                            ser_q  <= 1'b1;
`ifdef MSSD_TX_IDLE_GAP_EN
                            state   <= GAP;
                            gap_cnt <= 4'(GAP_BITS - 1);
`else
                            state   <= IDLE;
                            busy_q  <= 1'b0;
`endif
                        end else if (bus.byte_valid) begin
                            ser_q    <= bus.byte_data[BYTE_BITS-1];
                            byte_cnt <= byte_cnt - 4'd1;
                            bit_cnt  <= '0;
                        end else begin
                            state   <= IDLE;
                            ser_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end else begin
                        ser_q   <= piso_sout;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end

`ifdef MSSD_TX_IDLE_GAP_EN
                GAP: begin
                    // Line held idle and busy kept high so start is ignored.
                    if (gap_cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    ser_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.serOut     = ser_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.byte_ready = byte_ready_c;

endmodule

// File: tb/tb_mssd_tx.sv
// Purpose: directed, table-driven bench for mssd_tx (default build and MSSD_TX_IDLE_GAP_EN build).
// Latency: outputs sampled on the falling edge; inputs changed 1 time unit after the rising edge.
// Backpressure: byte source is driven from each vector's byte list; underrun injected by hand.
module tb_mssd_tx;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mssd_tx_if bus ();

    mssd_tx #(.GAP_BITS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

`ifdef MSSD_TX_IDLE_GAP_EN
    localparam logic GAP_ON = 1'b1;
`else
    localparam logic GAP_ON = 1'b0;
`endif

    typedef struct {
        logic [1:0]  port;
        logic [3:0]  count;
        logic [23:0] bytes;   // first byte in [23:16]
        logic [30:0] exp;     // expected serOut for T1..Tlen, T1 in bit len-1
        int          len;
    } vec_t;

    vec_t vt[4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.port       = 2'b00;
        bus.count      = 4'd0;
        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            @(posedge clock);
            #1;
        end
        check1({name, "_idle_timeout"}, bus.busy, 1'b0);
    endtask

    task automatic run_frame(input int id, input vec_t v);
        logic [23:0] cur;
        logic        xfer;
        logic        exp_rdy;
        int          xfers;
        cur   = v.bytes;
        xfers = 0;
        bus.port       = v.port;
        bus.count      = v.count;
        bus.byte_data  = cur[23:16];
        bus.byte_valid = 1'b1;
        bus.start      = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= v.len + 1; k++) begin
            @(negedge clock);
            if (k <= v.len) begin
                exp_rdy = (k >= 7) && (((k - 7) % 8) == 0) && (((k - 7) / 8) < int'(v.count));
                check1($sformatf("v%0d_ser_T%0d", id, k), bus.serOut, v.exp[v.len - k]);
                check1($sformatf("v%0d_busy_T%0d", id, k), bus.busy, 1'b1);
                check1($sformatf("v%0d_rdy_T%0d", id, k), bus.byte_ready, exp_rdy);
                check1($sformatf("v%0d_done_T%0d", id, k), bus.done, 1'b0);
            end else begin
                check1($sformatf("v%0d_done_pulse", id), bus.done, 1'b1);
                check1($sformatf("v%0d_ser_done", id), bus.serOut, 1'b1);
                check1($sformatf("v%0d_busy_done", id), bus.busy, GAP_ON);
                check1($sformatf("v%0d_err_done", id), bus.error, 1'b0);
                check1($sformatf("v%0d_rdy_done", id), bus.byte_ready, 1'b0);
            end
            xfer = bus.byte_ready & bus.byte_valid;
            @(posedge clock);
            #1;
            if (xfer) begin
                xfers++;
                cur = cur << 8;
                bus.byte_data = cur[23:16];
            end
        end
        checkn($sformatf("v%0d_xfers", id), xfers, int'(v.count));
        bus.byte_valid = 1'b0;
        wait_idle($sformatf("v%0d", id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{port: 2'b10, count: 4'd1, bytes: 24'hA50000,
                  exp: 31'b0_10_0001_10100101, len: 15};
        vt[1] = '{port: 2'b01, count: 4'd3, bytes: 24'h01FF80,
                  exp: 31'b0_01_0011_00000001_11111111_10000000, len: 31};
        vt[2] = '{port: 2'b11, count: 4'd2, bytes: 24'h3CC300,
                  exp: 31'b0_11_0010_00111100_11000011, len: 23};
        vt[3] = '{port: 2'b01, count: 4'd1, bytes: 24'h5A0000,
                  exp: 31'b0_01_0001_01011010, len: 15};

        idle_inputs();

        // Reset state, checked between edges while reset is held.
        #12;
        check1("rst_ser", bus.serOut, 1'b1);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_done", bus.done, 1'b0);
        check1("rst_err", bus.error, 1'b0);
        check1("rst_rdy", bus.byte_ready, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven frames.
        for (int i = 0; i < 4; i++) begin
            run_frame(i, vt[i]);
        end

        // Rejected request: count = 0.
        bus.port  = 2'b11;
        bus.count = 4'd0;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(negedge clock);
        check1("rej_err", bus.error, 1'b1);
        check1("rej_ser", bus.serOut, 1'b1);
        check1("rej_busy", bus.busy, 1'b0);
        check1("rej_rdy", bus.byte_ready, 1'b0);
        @(negedge clock);
        check1("rej_err_pulse", bus.error, 1'b0);
        check1("rej_busy2", bus.busy, 1'b0);

        // Underrun on the second byte of a two-byte frame.
        bus.port       = 2'b01;
        bus.count      = 4'd2;
        bus.byte_data  = 8'hC3;
        bus.byte_valid = 1'b1;
        bus.start      = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            bus.byte_valid = (k != 15);
            @(negedge clock);
            if (k == 1)  check1("ur_startbit", bus.serOut, 1'b0);
            if (k == 7)  check1("ur_rdy_T7", bus.byte_ready, 1'b1);
            if (k == 8)  check1("ur_ser_T8", bus.serOut, 1'b1);
            if (k == 9)  check1("ur_ser_T9", bus.serOut, 1'b1);
            if (k == 10) check1("ur_ser_T10", bus.serOut, 1'b0);
            if (k == 15) check1("ur_rdy_T15", bus.byte_ready, 1'b1);
            if (k == 16) begin
                check1("ur_err", bus.error, 1'b1);
                check1("ur_ser", bus.serOut, 1'b1);
                check1("ur_busy", bus.busy, 1'b0);
            end
            if (k >= 16) check1($sformatf("ur_nodone_T%0d", k), bus.done, 1'b0);
            if (k == 17) check1("ur_err_pulse", bus.error, 1'b0);
            @(posedge clock);
            #1;
        end
        idle_inputs();

        // Reset during the header aborts immediately; a later frame is clean.
        bus.port       = 2'b10;
        bus.count      = 4'd1;
        bus.byte_data  = 8'hA5;
        bus.byte_valid = 1'b1;
        bus.start      = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check1("mid_busy_before", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        check1("mid_ser_async", bus.serOut, 1'b1);
        check1("mid_busy_async", bus.busy, 1'b0);
        check1("mid_rdy_async", bus.byte_ready, 1'b0);
        @(negedge clock);
        check1("mid_done", bus.done, 1'b0);
        check1("mid_err", bus.error, 1'b0);
        reset = 1'b0;
        idle_inputs();
        run_frame(10, vt[0]);

        // Back-to-back: start held high across the frame end.
        bus.port       = 2'b10;
        bus.count      = 4'd1;
        bus.byte_data  = 8'hA5;
        bus.byte_valid = 1'b1;
        bus.start      = 1'b1;
        repeat (16) @(posedge clock);
        @(negedge clock);
        check1("b2b_done_T16", bus.done, 1'b1);
        check1("b2b_ser_T16", bus.serOut, 1'b1);
`ifdef MSSD_TX_IDLE_GAP_EN
        check1("b2b_busy_T16", bus.busy, 1'b1);
        @(negedge clock);
        check1("b2b_ser_T17", bus.serOut, 1'b1);
        check1("b2b_busy_T17", bus.busy, 1'b1);
        check1("b2b_done_T17", bus.done, 1'b0);
        @(negedge clock);
        check1("b2b_ser_T18", bus.serOut, 1'b1);
        check1("b2b_busy_T18", bus.busy, 1'b0);
        @(negedge clock);
        check1("b2b_ser_T19", bus.serOut, 1'b0);
        check1("b2b_busy_T19", bus.busy, 1'b1);
`else
        check1("b2b_busy_T16", bus.busy, 1'b0);
        @(negedge clock);
        check1("b2b_ser_T17", bus.serOut, 1'b0);
        check1("b2b_busy_T17", bus.busy, 1'b1);
        check1("b2b_done_T17", bus.done, 1'b0);
`endif
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check1("final_idle_ser", bus.serOut, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
